// File: rtl/evr_frame_rx.sv
// Event-receiver RX frame parser: event decode, distributed bus, segment reassembly.
// Optional checksum check of segment frames is enabled by defining EVR_SEG_CKSUM_EN.
module evr_frame_rx #(
    parameter int          SEG_BYTES = 16,
    parameter logic [7:0]  K_COMMA   = 8'hBC,
    parameter logic [7:0]  K_START   = 8'h5C,
    parameter logic [7:0]  K_STOP    = 8'h3C
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid,
    input  logic [15:0]                rx_data,
    input  logic [1:0]                 rx_isk,
    output logic [7:0]                 ev,
    output logic [7:0]                 dbus,
    output logic                       phase_ok,
    output logic                       seg_valid,
    output logic [7:0]                 seg_addr,
    output logic [SEG_BYTES*8-1:0]     seg_data,
    output logic                       seg_err,
    output logic [15:0]                err_cnt
);

    // state  | meaning
    // S_IDLE | waiting for K_START
    // S_ADDR | expecting segment address byte
    // S_DATA | collecting SEG_BYTES payload bytes
    // S_STOP | expecting K_STOP
    // S_CK_H | expecting checksum high byte
    // S_CK_L | expecting checksum low byte, then decide
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_STOP, S_CK_H, S_CK_L
    } state_t;

    localparam int CW = $clog2(SEG_BYTES);

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [7:0]                addr_q, addr_d;
    logic [SEG_BYTES*8-1:0]    shadow_q, shadow_d;
    logic                      ph_q;
    logic                      err_d, good_d;
`ifdef EVR_SEG_CKSUM_EN
    logic [15:0]               sum_q, sum_d;
    logic [7:0]                ckh_q, ckh_d;
`endif

    logic       comma, dbus_phase, data_ok, seg_stb, dbus_stb, byte_k, is_start;
    logic [7:0] byte_d;

    assign byte_d     = rx_data[7:0];
    assign byte_k     = rx_isk[0];
    assign is_start   = byte_k && (byte_d == K_START);
    assign comma      = rx_isk[1] && (rx_data[15:8] == K_COMMA);
    // ph_q predicts the dbus phase; a comma forces realignment
    assign dbus_phase = comma || ph_q;
    assign data_ok    = phase_ok || comma;
    assign seg_stb    = rx_valid && data_ok && !dbus_phase;
    assign dbus_stb   = rx_valid && data_ok && dbus_phase;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        shadow_d = shadow_q;
        err_d    = 1'b0;
        good_d   = 1'b0;
`ifdef EVR_SEG_CKSUM_EN
        sum_d    = sum_q;
        ckh_d    = ckh_q;
`endif
        if (seg_stb) begin
            if (is_start && state_q != S_IDLE) begin
                err_d   = 1'b1;
                state_d = S_ADDR;
            end else begin
                case (state_q)
                    S_IDLE: if (is_start) state_d = S_ADDR;
                    S_ADDR: begin
                        if (byte_k) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            addr_d  = byte_d;
                            cnt_d   = '0;
                            state_d = S_DATA;
`ifdef EVR_SEG_CKSUM_EN
                            sum_d   = {8'h00, byte_d};
`endif
                        end
                    end
                    S_DATA: begin
                        if (byte_k) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            shadow_d[(SEG_BYTES-1-int'(cnt_q))*8 +: 8] = byte_d;
`ifdef EVR_SEG_CKSUM_EN
                            sum_d = sum_q + {8'h00, byte_d};
`endif
                            if (cnt_q == CW'(SEG_BYTES-1)) state_d = S_STOP;
                            else                           cnt_d   = cnt_q + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (byte_k && byte_d == K_STOP) begin
                            state_d = S_CK_H;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    S_CK_H: begin
                        if (byte_k) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_CK_L;
`ifdef EVR_SEG_CKSUM_EN
                            ckh_d   = byte_d;
`endif
                        end
                    end
                    S_CK_L: begin
                        state_d = S_IDLE;
                        if (byte_k) begin
                            err_d = 1'b1;
                        end else begin
`ifdef EVR_SEG_CKSUM_EN
                            if ({ckh_q, byte_d} == (16'hFFFF - sum_q)) good_d = 1'b1;
                            else                                         err_d  = 1'b1;
`else
                            good_d = 1'b1;
`endif
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !rx_valid) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            shadow_q  <= '0;
            ph_q      <= 1'b0;
            phase_ok  <= 1'b0;
            ev        <= '0;
            dbus      <= '0;
            seg_valid <= 1'b0;
            seg_err   <= 1'b0;
            seg_addr  <= '0;
            seg_data  <= '0;
`ifdef EVR_SEG_CKSUM_EN
            sum_q     <= '0;
            ckh_q     <= '0;
`endif
            // link loss keeps the error history
            if (rst) err_cnt <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            shadow_q  <= shadow_d;
            ph_q      <= !dbus_phase;
            if (comma) phase_ok <= 1'b1;
            ev        <= rx_isk[1] ? 8'h00 : rx_data[15:8];
            if (dbus_stb) dbus <= byte_d;
            seg_valid <= good_d;
            seg_err   <= err_d;
            if (good_d) begin
                seg_addr <= addr_q;
                seg_data <= shadow_q;
            end
`ifdef EVR_SEG_CKSUM_EN
            sum_q     <= sum_d;
            ckh_q     <= ckh_d;
`endif
            if (err_d && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_evr_frame_rx.sv
// Directed self-checking bench for evr_frame_rx: vector table plus frame sequences.
module tb_evr_frame_rx;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [15:0]   rx_data;
    logic [1:0]    rx_isk;
    logic [7:0]    ev, dbus, seg_addr;
    logic          phase_ok, seg_valid, seg_err;
    logic [127:0]  seg_data;
    logic [15:0]   err_cnt;

    int checks = 0;
    int errors = 0;
    int sv_cnt = 0;
    int se_cnt = 0;

    evr_frame_rx dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_isk(rx_isk),
        .ev(ev), .dbus(dbus), .phase_ok(phase_ok), .seg_valid(seg_valid),
        .seg_addr(seg_addr), .seg_data(seg_data), .seg_err(seg_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [1:0]  k;
        logic [7:0]  ev;
        logic [7:0]  dbus;
        logic        pok;
    } vec_t;

    localparam logic [127:0] PAY1 = 128'h0008_0000_0000_0007_0000_0000_0000_0007;
    localparam logic [127:0] PAY2 = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic [1:0] k);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        rx_isk   = k;
        @(posedge clk);
        #1;
        sv_cnt += int'(seg_valid);
        se_cnt += int'(seg_err);
        chk("valid_err_exclusive", {127'd0, seg_valid & seg_err}, 128'd0);
    endtask

    // one seg-phase byte followed by one dbus-phase filler
    task automatic sb(input logic [7:0] b, input logic k);
        step(1'b1, {8'h00, b}, {1'b0, k});
        step(1'b1, 16'h0000, 2'b00);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [127:0] p,
                              input logic [7:0] ckh, input logic [7:0] ckl);
        logic [127:0] pv;
        pv = p;
        sb(8'h5C, 1'b1);
        sb(a, 1'b0);
        for (int i = 0; i < 16; i++) sb(pv[127-8*i -: 8], 1'b0);
        sb(8'h3C, 1'b1);
        sb(ckh, 1'b0);
        sb(ckl, 1'b0);
    endtask

    vec_t tv[8];
    int   sv0, se0;
    int   exp_err;

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_isk = '0;
        exp_err = 0;
        tv[0] = '{1'b1, 16'h1577, 2'b00, 8'h15, 8'h00, 1'b0};
        tv[1] = '{1'b1, 16'hBC00, 2'b10, 8'h00, 8'h00, 1'b1};
        tv[2] = '{1'b1, 16'h7E00, 2'b00, 8'h7E, 8'h00, 1'b1};
        tv[3] = '{1'b1, 16'h15A5, 2'b00, 8'h15, 8'hA5, 1'b1};
        tv[4] = '{1'b1, 16'h0033, 2'b00, 8'h00, 8'hA5, 1'b1};
        tv[5] = '{1'b1, 16'hBC5A, 2'b10, 8'h00, 8'h5A, 1'b1};
        tv[6] = '{1'b1, 16'h0011, 2'b00, 8'h00, 8'h5A, 1'b1};
        tv[7] = '{1'b1, 16'h7EC3, 2'b10, 8'h00, 8'hC3, 1'b1};

        step(1'b1, 16'h1234, 2'b00);
        step(1'b1, 16'h1234, 2'b00);
        chk("rst_ev", {120'd0, ev}, 128'd0);
        chk("rst_dbus", {120'd0, dbus}, 128'd0);
        chk("rst_phase_ok", {127'd0, phase_ok}, 128'd0);
        chk("rst_seg_addr", {120'd0, seg_addr}, 128'd0);
        chk("rst_seg_data", seg_data, 128'd0);
        chk("rst_err_cnt", {112'd0, err_cnt}, 128'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            step(tv[i].v, tv[i].d, tv[i].k);
            chk($sformatf("vec%0d_ev", i), {120'd0, ev}, {120'd0, tv[i].ev});
            chk($sformatf("vec%0d_dbus", i), {120'd0, dbus}, {120'd0, tv[i].dbus});
            chk($sformatf("vec%0d_phase_ok", i), {127'd0, phase_ok}, {127'd0, tv[i].pok});
        end
        chk("idle_no_seg", {96'd0, sv_cnt[15:0], se_cnt[15:0]}, 128'd0);

        // good frame
        sv0 = sv_cnt; se0 = se_cnt;
        send_frame(8'hFF, PAY1, 8'hFE, 8'hEA);
        chk("good_valid_pulses", 128'(sv_cnt - sv0), 128'd1);
        chk("good_err_pulses", 128'(se_cnt - se0), 128'd0);
        chk("good_addr", {120'd0, seg_addr}, {120'd0, 8'hFF});
        chk("good_data", seg_data, PAY1);
        chk("good_err_cnt", {112'd0, err_cnt}, 128'd0);

        // bad checksum
        sv0 = sv_cnt; se0 = se_cnt;
        send_frame(8'hFF, PAY1, 8'hFE, 8'hEB);
`ifdef EVR_SEG_CKSUM_EN
        exp_err++;
        chk("bad_err_pulses", 128'(se_cnt - se0), 128'd1);
        chk("bad_valid_pulses", 128'(sv_cnt - sv0), 128'd0);
`else
        chk("bad_err_pulses", 128'(se_cnt - se0), 128'd0);
        chk("bad_valid_pulses", 128'(sv_cnt - sv0), 128'd1);
`endif
        chk("bad_err_cnt", {112'd0, err_cnt}, 128'(exp_err));
        chk("bad_data_held", seg_data, PAY1);

        // abort by new K_START, then good frame to addr 02
        sv0 = sv_cnt; se0 = se_cnt;
        sb(8'h5C, 1'b1);
        sb(8'h01, 1'b0);
        for (int i = 0; i < 4; i++) sb(8'h44, 1'b0);
        chk("abort_no_leak", seg_data, PAY1);
        send_frame(8'h02, PAY2, 8'hFF, 8'h75);
        exp_err++;
        chk("abort_err_pulses", 128'(se_cnt - se0), 128'd1);
        chk("abort_valid_pulses", 128'(sv_cnt - sv0), 128'd1);
        chk("abort_addr", {120'd0, seg_addr}, {120'd0, 8'h02});
        chk("abort_data", seg_data, PAY2);
        chk("abort_err_cnt", {112'd0, err_cnt}, 128'(exp_err));

        // link loss mid-DATA
        sv0 = sv_cnt; se0 = se_cnt;
        sb(8'h5C, 1'b1);
        sb(8'h03, 1'b0);
        sb(8'h01, 1'b0);
        sb(8'h02, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h7EA5, 2'b00);
            chk($sformatf("down%0d_ev", i), {120'd0, ev}, 128'd0);
            chk($sformatf("down%0d_phase_ok", i), {127'd0, phase_ok}, 128'd0);
            chk($sformatf("down%0d_dbus", i), {120'd0, dbus}, 128'd0);
            chk($sformatf("down%0d_err_cnt", i), {112'd0, err_cnt}, 128'(exp_err));
        end
        step(1'b1, 16'hBC00, 2'b10);
        chk("relock_phase_ok", {127'd0, phase_ok}, 128'd1);
        send_frame(8'hFF, PAY1, 8'hFE, 8'hEA);
        chk("relock_addr", {120'd0, seg_addr}, {120'd0, 8'hFF});
        chk("relock_data", seg_data, PAY1);
        send_frame(8'h02, PAY2, 8'hFF, 8'h75);
        chk("b2b_addr", {120'd0, seg_addr}, {120'd0, 8'h02});
        chk("link_valid_pulses", 128'(sv_cnt - sv0), 128'd2);
        chk("link_err_pulses", 128'(se_cnt - se0), 128'd0);
        chk("link_err_cnt", {112'd0, err_cnt}, 128'(exp_err));

        // reset mid-frame
        sb(8'h5C, 1'b1);
        sb(8'h05, 1'b0);
        sb(8'hAA, 1'b0);
        rst = 1'b1;
        step(1'b1, 16'h1122, 2'b00);
        chk("mrst_ev", {120'd0, ev}, 128'd0);
        chk("mrst_dbus", {120'd0, dbus}, 128'd0);
        chk("mrst_phase_ok", {127'd0, phase_ok}, 128'd0);
        chk("mrst_seg_valid", {127'd0, seg_valid}, 128'd0);
        chk("mrst_seg_err", {127'd0, seg_err}, 128'd0);
        chk("mrst_seg_addr", {120'd0, seg_addr}, 128'd0);
        chk("mrst_seg_data", seg_data, 128'd0);
        chk("mrst_err_cnt", {112'd0, err_cnt}, 128'd0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
